pipe_perf_mon: RTL and testbench
================================

# pipe_perf_mon

Non-intrusive performance and halt monitor attached to the retirement side of the forwarding pipeline core. Samples the core's instruction-valid strobe, debug PC and IF-stage instruction word each cycle. Accumulates cycle, retired-instruction, bubble and control-redirect counts, and detects the end-of-program marker. Results are exposed through a registered read port for the I/O subsystem and for bench self-checking.

## Interface
- CNT_W, 32: width of every event counter (1..32); zero-extended to 32 bits on read.
- HALT_INSN, 32'h1111_1111: IF-stage instruction word that marks program end.
- DRAIN_CYC, 4: cycles counted after halt detection so in-flight instructions retire; range 1..15.
- i_clk  in  1  core clock.
- i_rst  in  1  synchronous active-high reset; one clock, synchronous reset, active-high.
- i_en  in  1  start counting (level; sampled in IDLE only).
- i_clr  in  1  synchronous clear of counters and state, same effect as i_rst.
- i_insn_vld  in  1  core retirement strobe (one instruction per asserted cycle).
- i_pc_debug  in  32  PC of the retiring instruction, valid when i_insn_vld=1.
- i_if_instr  in  32  instruction currently in IF.
- i_rd_sel  in  3  read register select.
- o_rd_data  out  32  registered read data.
- o_running  out  1  state is RUN or DRAIN.
- o_halted  out  1  state is HALTED.

## Operation
- States: IDLE, RUN, DRAIN, HALTED.
  - IDLE -> RUN when i_en=1.
  - RUN -> DRAIN when i_if_instr==HALT_INSN; the drain counter loads DRAIN_CYC-1.
  - DRAIN -> HALTED when the drain counter is 0; otherwise it decrements.
  - HALTED is held until i_rst or i_clr.
  - HALT_INSN is ignored in IDLE, DRAIN and HALTED.
- Counters advance only on edges where the pre-edge state is RUN or DRAIN:
  - cycle_cnt: +1 every such edge.
  - instr_cnt: +1 when i_insn_vld=1.
  - bubble_cnt: +1 when i_insn_vld=0.
  - redir_cnt: +1 when i_insn_vld=1, pc_seen=1 and i_pc_debug != last_pc+4 (mod 2^32).
- last_pc and pc_seen:
  - last_pc captures i_pc_debug on each counted retirement.
  - pc_seen is set by the first counted retirement.
  - The first retirement after start never counts as a redirect.
- All counters saturate at 2^CNT_W-1 and never wrap. Saturation of one counter does not affect the others.
- Invariant while no counter is saturated: cycle_cnt == instr_cnt + bubble_cnt.
- Read map for i_rd_sel:
  - 0 cycle_cnt, 1 instr_cnt, 2 bubble_cnt, 3 redir_cnt, 4 last_pc.
  - 5 status: bit0 = o_running, bit1 = o_halted, bits 31:2 = 0.
  - 6 and 7 read as 0.
- Clear and reset:
  - i_rst or i_clr zeroes all counters, last_pc, pc_seen, the drain counter and o_rd_data, and forces IDLE.
  - Clear has priority over every other event in the same cycle, including an active halt detection.
- Asserting i_en in HALTED has no effect.

## Timing
- Reset values: o_rd_data=0, o_running=0, o_halted=0; state IDLE.
- Outputs are registered. o_running and o_halted change on the edge that changes state.
- o_rd_data is 1-cycle latency: it reflects i_rd_sel and the counter values from before the same edge.
- The edge that moves IDLE->RUN is not counted.
- The edge that detects HALT_INSN is counted (state is RUN), and so are all DRAIN_CYC DRAIN edges.
- With a continuously valid core, exactly 1+DRAIN_CYC counted edges occur from halt detection to HALTED.
- Reset or clear applied mid-RUN or mid-DRAIN takes effect on that edge: all values read 0 one cycle later.

## Structure
- Package pipe_perf_pkg holds:
  - the state enum (IDLE/RUN/DRAIN/HALTED);
  - read-select localparams (SEL_CYC..SEL_STAT);
  - the default HALT_INSN constant.
- Sub-module sat_counter (parameter W; ports i_clk, i_rst, i_clr, i_inc, o_cnt) is instantiated four times.
- The top level contains the FSM, drain counter, redirect compare and read mux.

## Test plan
- **Reset/idle:** reset, then i_en=0 for 10 cycles with i_insn_vld toggling -> every read returns 0; status reads 0.
- **Straight-line run:**
  - Stimulus: i_en=1, then 8 consecutive retirements at PC 0x0,0x4,...,0x1C, then 2 bubbles, then HALT_INSN in IF with DRAIN_CYC=4.
  - Required: halted after 4 drain cycles; instr=8; redir=0; last_pc=0x1C; cycle=instr+bubble.
- **Redirects:**
  - Stimulus: retirement PC sequence 0x0,0x4,0x40,0x44,0x8.
  - Required: redir_cnt=2; no redirect on the first PC.
- **Saturation:** CNT_W=4, 20 counted cycles -> cycle_cnt holds at 15; status still running.
- **Clear priority:** i_clr in the same cycle as HALT_INSN mid-RUN -> next cycle IDLE, all reads 0; a later HALT_INSN in IDLE is ignored.
- **Read latency:** change i_rd_sel 0->1->5 on successive cycles -> o_rd_data follows one cycle later with the correct values.

Source files
------------

// File: rtl/pipe_perf_pkg.sv
// Shared types and constants for the retirement-side performance/halt monitor.
package pipe_perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_e;

  localparam logic [2:0] SEL_CYC   = 3'd0;
  localparam logic [2:0] SEL_INSTR = 3'd1;
  localparam logic [2:0] SEL_BUB   = 3'd2;
  localparam logic [2:0] SEL_REDIR = 3'd3;
  localparam logic [2:0] SEL_PC    = 3'd4;
  localparam logic [2:0] SEL_STAT  = 3'd5;

  localparam logic [31:0] HALT_INSN_DEFAULT = 32'h1111_1111;

endpackage

// File: rtl/pipe_perf_mon_if.sv
// Core-side sampling signals and the registered read port of the monitor.
interface pipe_perf_mon_if;
  logic        i_en;
  logic        i_clr;
  logic        i_insn_vld;
  logic [31:0] i_pc_debug;
  logic [31:0] i_if_instr;
  logic [2:0]  i_rd_sel;
  logic [31:0] o_rd_data;
  logic        o_running;
  logic        o_halted;

  modport master (
    output i_en, i_clr, i_insn_vld, i_pc_debug, i_if_instr, i_rd_sel,
    input  o_rd_data, o_running, o_halted
  );

  modport slave (
    input  i_en, i_clr, i_insn_vld, i_pc_debug, i_if_instr, i_rd_sel,
    output o_rd_data, o_running, o_halted
  );
endinterface

// File: rtl/pipe_perf_mon_sat_counter.sv
// Event counter that sticks at its all-ones maximum instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  localparam logic [W-1:0] ONE = 1;
  localparam logic [W-1:0] MAX = '1;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == MAX) ? v : v + ONE;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      o_cnt <= '0;
    end else if (i_inc) begin
      o_cnt <= sat_inc(o_cnt);
    end
  end

endmodule

// File: rtl/pipe_perf_mon.sv
// Performance and halt monitor: run/drain FSM, event counters, redirect detect, read mux.
module pipe_perf_mon
  import pipe_perf_pkg::*;
#(
  parameter int          CNT_W     = 32,
  parameter logic [31:0] HALT_INSN = HALT_INSN_DEFAULT,
  parameter int          DRAIN_CYC = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  pipe_perf_mon_if.slave  mon
);

  state_e           state_q, state_nxt;
  logic [3:0]       drain_q, drain_nxt;
  logic [31:0]      last_pc_q;
  logic             pc_seen_q;
  logic             running_q, halted_q;
  logic [31:0]      rd_data_q, rd_mux;
  logic [CNT_W-1:0] cyc_cnt, instr_cnt, bub_cnt, redir_cnt;
  logic             clear, counting, retire, bubble, redirect;

  assign clear    = i_rst | mon.i_clr;
  assign counting = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign retire   = counting & mon.i_insn_vld;
  assign bubble   = counting & ~mon.i_insn_vld;
  // The first retirement after start has no predecessor, so pc_seen gates it out.
  assign redirect = retire & pc_seen_q & (mon.i_pc_debug != last_pc_q + 32'd4);

  sat_counter #(.W(CNT_W)) u_cyc (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(mon.i_clr), .i_inc(counting), .o_cnt(cyc_cnt)
  );
  sat_counter #(.W(CNT_W)) u_instr (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(mon.i_clr), .i_inc(retire), .o_cnt(instr_cnt)
  );
  sat_counter #(.W(CNT_W)) u_bub (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(mon.i_clr), .i_inc(bubble), .o_cnt(bub_cnt)
  );
  sat_counter #(.W(CNT_W)) u_redir (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(mon.i_clr), .i_inc(redirect), .o_cnt(redir_cnt)
  );

  always_comb begin
    state_nxt = state_q;
    drain_nxt = drain_q;
    case (state_q)
      ST_IDLE:   if (mon.i_en) state_nxt = ST_RUN;
      ST_RUN: begin
        if (mon.i_if_instr == HALT_INSN) begin
          state_nxt = ST_DRAIN;
          drain_nxt = 4'(DRAIN_CYC - 1);
        end
      end
      ST_DRAIN: begin
        if (drain_q == 4'd0) state_nxt = ST_HALTED;
        else                 drain_nxt = drain_q - 4'd1;
      end
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (mon.i_rd_sel)
      SEL_CYC:   rd_mux = 32'(cyc_cnt);
      SEL_INSTR: rd_mux = 32'(instr_cnt);
      SEL_BUB:   rd_mux = 32'(bub_cnt);
      SEL_REDIR: rd_mux = 32'(redir_cnt);
      SEL_PC:    rd_mux = last_pc_q;
      SEL_STAT:  rd_mux = {30'd0, halted_q, running_q};
      default:   rd_mux = '0;
    endcase
  end

  // Clear wins over everything, including a halt marker seen on the same edge.
  always_ff @(posedge i_clk) begin
    if (clear) begin
      state_q   <= ST_IDLE;
      drain_q   <= 4'd0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
      last_pc_q <= '0;
      pc_seen_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_nxt;
      drain_q   <= drain_nxt;
      running_q <= (state_nxt == ST_RUN) || (state_nxt == ST_DRAIN);
      halted_q  <= (state_nxt == ST_HALTED);
      rd_data_q <= rd_mux;
      if (retire) begin
        last_pc_q <= mon.i_pc_debug;
        pc_seen_q <= 1'b1;
      end
    end
  end

  assign mon.o_rd_data = rd_data_q;
  assign mon.o_running = running_q;
  assign mon.o_halted  = halted_q;

endmodule

// File: tb/tb_pipe_perf_mon.sv
// Directed and randomized checks of pipe_perf_mon (32-bit and 4-bit counter builds).
module tb_pipe_perf_mon;

  localparam logic [31:0] HALT = 32'h1111_1111;
  localparam int          DRAIN = 4;

  logic        clk = 1'b0;
  logic        rst, en, clr, vld;
  logic [31:0] pc, instr;
  logic [2:0]  sel;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 run, 2 drain, 3 halted; counts kept unsaturated.
  int          phase;
  int          drain_left;
  longint      m_cyc, m_instr, m_bub, m_redir;
  logic [31:0] m_last;
  bit          m_seen;

  pipe_perf_mon_if if_a ();
  pipe_perf_mon_if if_b ();

  assign if_a.i_en = en;       assign if_b.i_en = en;
  assign if_a.i_clr = clr;     assign if_b.i_clr = clr;
  assign if_a.i_insn_vld = vld; assign if_b.i_insn_vld = vld;
  assign if_a.i_pc_debug = pc;  assign if_b.i_pc_debug = pc;
  assign if_a.i_if_instr = instr; assign if_b.i_if_instr = instr;
  assign if_a.i_rd_sel = sel;   assign if_b.i_rd_sel = sel;

  pipe_perf_mon #(.CNT_W(32), .HALT_INSN(HALT), .DRAIN_CYC(DRAIN)) u_a (
    .i_clk(clk), .i_rst(rst), .mon(if_a)
  );
  pipe_perf_mon #(.CNT_W(4), .HALT_INSN(HALT), .DRAIN_CYC(DRAIN)) u_b (
    .i_clk(clk), .i_rst(rst), .mon(if_b)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] satv(input longint v, input int w);
    longint maxv;
    maxv = (longint'(1) << w) - 1;
    return (v > maxv) ? 32'(maxv) : 32'(v);
  endfunction

  function automatic logic [31:0] rd_model(input logic [2:0] s, input int w);
    case (s)
      3'd0: return satv(m_cyc, w);
      3'd1: return satv(m_instr, w);
      3'd2: return satv(m_bub, w);
      3'd3: return satv(m_redir, w);
      3'd4: return m_last;
      3'd5: return {30'd0, phase == 3, phase == 1 || phase == 2};
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] non_halt();
    return $urandom & 32'h0FFF_FFFF;
  endfunction

  // One clock: predict from pre-edge model state, advance model, compare after edge.
  task automatic tick();
    logic [31:0] ea, eb;
    bit counted;
    if (rst || clr) begin
      ea = 32'd0; eb = 32'd0;
      phase = 0; drain_left = 0;
      m_cyc = 0; m_instr = 0; m_bub = 0; m_redir = 0;
      m_last = 32'd0; m_seen = 0;
    end else begin
      ea = rd_model(sel, 32);
      eb = rd_model(sel, 4);
      counted = (phase == 1 || phase == 2);
      if (counted) begin
        m_cyc++;
        if (vld) begin
          m_instr++;
          if (m_seen && pc != m_last + 32'd4) m_redir++;
          m_last = pc;
          m_seen = 1;
        end else begin
          m_bub++;
        end
      end
      if (phase == 0 && en) phase = 1;
      else if (phase == 1 && instr == HALT) begin
        phase = 2;
        drain_left = DRAIN;
      end else if (phase == 2) begin
        drain_left--;
        if (drain_left == 0) phase = 3;
      end
    end
    @(posedge clk);
    #1;
    chk("rd_data_w32", if_a.o_rd_data, ea);
    chk("rd_data_w4", if_b.o_rd_data, eb);
    chk("running_w32", 32'(if_a.o_running), 32'(phase == 1 || phase == 2));
    chk("halted_w32", 32'(if_a.o_halted), 32'(phase == 3));
    chk("running_w4", 32'(if_b.o_running), 32'(phase == 1 || phase == 2));
    chk("halted_w4", 32'(if_b.o_halted), 32'(phase == 3));
  endtask

  task automatic rd(input logic [2:0] s, output logic [31:0] va, output logic [31:0] vb);
    sel = s;
    tick();
    va = if_a.o_rd_data;
    vb = if_b.o_rd_data;
  endtask

  initial begin
    logic [31:0] va, vb, c_val, i_val, b_val;
    logic [31:0] redir_pcs [5];
    redir_pcs[0] = 32'h0;  redir_pcs[1] = 32'h4; redir_pcs[2] = 32'h40;
    redir_pcs[3] = 32'h44; redir_pcs[4] = 32'h8;
    phase = 0; drain_left = 0;
    m_cyc = 0; m_instr = 0; m_bub = 0; m_redir = 0; m_last = 0; m_seen = 0;

    rst = 1; en = 0; clr = 0; vld = 0; pc = 0; instr = 0; sel = 0;
    tick();
    rst = 0;

    // Idle with toggling retirement strobe: nothing counts.
    for (int i = 0; i < 10; i++) begin
      vld = i[0]; sel = 3'(i % 8); pc = $urandom; instr = $urandom;
      tick();
    end
    rd(3'd5, va, vb);
    chk("idle_status", va, 32'd0);

    // Straight-line program then halt marker.
    en = 1; vld = 0; instr = non_halt();
    tick();
    for (int i = 0; i < 8; i++) begin
      vld = 1; pc = 32'(i * 4); instr = non_halt();
      tick();
    end
    vld = 0;
    tick(); tick();
    instr = HALT;
    tick();
    instr = non_halt();
    for (int i = 0; i < DRAIN; i++) tick();
    chk("halted_after_drain", 32'(if_a.o_halted), 32'd1);
    rd(3'd1, i_val, vb); chk("line_instr", i_val, 32'd8);
    rd(3'd3, va, vb);    chk("line_redir", va, 32'd0);
    rd(3'd4, va, vb);    chk("line_last_pc", va, 32'h1C);
    rd(3'd0, c_val, vb); chk("line_cycles", c_val, 32'd15);
    rd(3'd2, b_val, vb); chk("line_cyc_sum", c_val, i_val + b_val);
    rd(3'd5, va, vb);    chk("halted_holds_en", va, 32'd2);

    // Redirect detection after a clear.
    clr = 1; tick(); clr = 0;
    en = 1; vld = 0; instr = non_halt();
    tick();
    for (int i = 0; i < 5; i++) begin
      vld = 1; pc = redir_pcs[i];
      tick();
      vld = 0;
      if ($urandom_range(0, 1) == 1) tick();
    end
    rd(3'd3, va, vb); chk("redir_count", va, 32'd2);
    rd(3'd4, va, vb); chk("redir_last_pc", va, 32'h8);

    // Saturation of the narrow build.
    for (int i = 0; i < 20; i++) begin
      vld = 1'($urandom); pc = m_last + 32'd4; instr = non_halt();
      tick();
    end
    vld = 0;
    rd(3'd0, va, vb); chk("sat_cycles_w4", vb, 32'd15);
    rd(3'd5, va, vb); chk("sat_status_w4", vb, 32'd1);

    // Clear collides with a halt marker while running.
    clr = 1; instr = HALT; vld = 1;
    tick();
    clr = 0; en = 0; vld = 0;
    for (int s = 0; s < 6; s++) begin
      rd(3'(s), va, vb);
      chk("clr_prio_read", va, 32'd0);
    end

    // Read latency across successive selects.
    en = 1; instr = non_halt();
    tick();
    for (int i = 0; i < 6; i++) begin
      vld = 1'($urandom); pc = m_last + 32'd4;
      tick();
    end
    vld = 0;
    sel = 3'd0; tick();
    sel = 3'd1; tick();
    sel = 3'd5; tick();
    chk("latency_status", if_a.o_rd_data, 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 149) == 0);
      clr   = ($urandom_range(0, 99) == 0);
      en    = ($urandom_range(0, 3) != 0);
      vld   = 1'($urandom);
      pc    = ($urandom_range(0, 3) != 0) ? m_last + 32'd4 : ($urandom & 32'hFFFF_FFFC);
      instr = ($urandom_range(0, 39) == 0) ? HALT : non_halt();
      sel   = 3'($urandom_range(0, 7));
      tick();
    end
    rst = 0; clr = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
